fetch_unit_pq: RTL and testbench

Parametrised instruction-fetch front end for the 32-bit word-addressed CPU. It is the next generation of the PC/IR portion of the data path. It owns the program counter, issues requests over an instruction-memory handshake that tolerates wait states, and buffers fetched words in a DEPTH-entry prefetch queue. Execute-stage redirects (branch/jump/jr) flush the queue and any in-flight fetch. Each queued instruction is handed to decode together with its PC.

---
 rtl/fetch_unit_pq_pkg.sv | 18 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_unit_pq.sv | 108 ++++++++++
 tb/tb_fetch_unit_pq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pq_pkg.sv
// Shared definitions for the fetch front end: FSM encoding, reset PC, queue count width.
package fetch_unit_pq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DROP = 2'b10
    } state_t;

    localparam logic [25:0] START_ADDR_DEF = 26'h0001000;

    function automatic int qcnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int QCNT_W_DEF = qcnt_w(4);

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO with a registered head word; flush empties it in one cycle.
module fetch_queue
    import fetch_unit_pq_pkg::*;
#(
    parameter int W     = 58,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [qcnt_w(DEPTH)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = qcnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd, wr, rd_n;

    assign rd_n = rd + PW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            head  <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + PW'(1);
            rd    <= rd_n;
            count <= count + CW'(push) - CW'(pop);
            // The new head is either the word being written this cycle or an older stored entry
            if (push && rd_n == wr) head <= din;
            else if (pop)           head <= mem[rd_n];
        end
    end

endmodule

// File: rtl/fetch_unit_pq.sv
// Instruction fetch front end: PC, single-outstanding imem handshake, prefetch queue.
// Optional STALL_CNT/DROP_CNT counters when FETCH_STALL_CNT_EN is defined.
module fetch_unit_pq
    import fetch_unit_pq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic                      IMEM_REQ,
    output logic [ADDR_WIDTH-1:0]     IMEM_ADDR,
    input  logic                      IMEM_ACK,
    input  logic [DATA_WIDTH-1:0]     IMEM_DATA,
    input  logic                      REDIRECT,
    input  logic [ADDR_WIDTH-1:0]     REDIRECT_ADDR,
    output logic                      INST_VALID,
    input  logic                      INST_READY,
    output logic [DATA_WIDTH-1:0]     INSTRUCTION,
    output logic [ADDR_WIDTH-1:0]     INST_PC,
    output logic [qcnt_w(DEPTH)-1:0]  Q_COUNT
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]               STALL_CNT,
    output logic [15:0]               DROP_CNT
`endif
);
    localparam int CW = qcnt_w(DEPTH);

    state_t                          state;
    logic [ADDR_WIDTH-1:0]           pc;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;
    logic                            xfer, push, pop;

    assign xfer       = IMEM_REQ && IMEM_ACK;
    assign push       = xfer && state == S_WAIT && !REDIRECT;
    assign pop        = INST_VALID && INST_READY && !REDIRECT;
    assign INST_VALID = Q_COUNT != '0;
    assign {INSTRUCTION, INST_PC} = head;

    fetch_queue #(.W(DATA_WIDTH + ADDR_WIDTH), .DEPTH(DEPTH)) u_queue (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .pop   (pop),
        .flush (REDIRECT),
        .din   ({IMEM_DATA, IMEM_ADDR}),
        .head  (head),
        .count (Q_COUNT)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pc        <= START_ADDR;
            IMEM_REQ  <= 1'b0;
            IMEM_ADDR <= START_ADDR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (REDIRECT) begin
                        pc <= REDIRECT_ADDR;
                    end else if (Q_COUNT < CW'(DEPTH)) begin
                        IMEM_REQ  <= 1'b1;
                        IMEM_ADDR <= pc;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ <= 1'b0;
                        state    <= S_IDLE;
                        pc       <= REDIRECT ? REDIRECT_ADDR : pc + ADDR_WIDTH'(1);
                    end else if (REDIRECT) begin
                        pc    <= REDIRECT_ADDR;
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // Request must stay up until memory answers; its data is thrown away
                    if (REDIRECT) pc <= REDIRECT_ADDR;
                    if (IMEM_ACK) begin
                        IMEM_REQ <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            STALL_CNT <= '0;
            DROP_CNT  <= '0;
        end else begin
            if (INST_READY && !INST_VALID && STALL_CNT != 32'hFFFF_FFFF)
                STALL_CNT <= STALL_CNT + 32'd1;
            if (xfer && (state == S_DROP || (state == S_WAIT && REDIRECT)))
                DROP_CNT <= DROP_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Self-checking bench for fetch_unit_pq: directed scenarios plus random traffic
// checked against a transaction-level queue/PC model.
module tb_fetch_unit_pq;
    import fetch_unit_pq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IMEM_REQ;
    logic [25:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_DATA = '0;
    logic        REDIRECT = 1'b0;
    logic [25:0] REDIRECT_ADDR = '0;
    logic        INST_VALID;
    logic        INST_READY = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [25:0] INST_PC;
    logic [QCNT_W_DEF-1:0] Q_COUNT;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] STALL_CNT;
    logic [15:0] DROP_CNT;
`endif

    fetch_unit_pq dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
        .INST_VALID(INST_VALID), .INST_READY(INST_READY),
        .INSTRUCTION(INSTRUCTION), .INST_PC(INST_PC), .Q_COUNT(Q_COUNT)
`ifdef FETCH_STALL_CNT_EN
        , .STALL_CNT(STALL_CNT), .DROP_CNT(DROP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [57:0] q[$];
    logic [25:0] m_pc;
    bit          m_drop_pend;
    int          m_xfers;
    logic [25:0] m_last;
    logic [15:0] m_drops;
    logic [31:0] m_stall;
    // Memory responder state
    bit          mpend;
    int          mwl;
    int          waits;
    bit          rand_waits;

    function automatic logic [31:0] mem_word(input logic [25:0] a);
        return {a, 6'h15} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_pc = 26'h0001000;
        m_drop_pend = 0;
        m_xfers = 0;
        m_last = '0;
        m_drops = '0;
        m_stall = '0;
        mpend = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; IMEM_ACK = 1'b0; INST_READY = 1'b0; REDIRECT = 1'b0;
        #2;
        chk("rst_req",   64'(IMEM_REQ),    64'd0);
        chk("rst_addr",  64'(IMEM_ADDR),   64'h1000);
        chk("rst_valid", 64'(INST_VALID),  64'd0);
        chk("rst_instr", 64'(INSTRUCTION), 64'd0);
        chk("rst_pc",    64'(INST_PC),     64'd0);
        chk("rst_count", 64'(Q_COUNT),     64'd0);
        @(negedge CLK);
        RST = 1'b1;
        model_clear();
    endtask

    // One clock: drive at negedge, predict the edge, check #1 after it, return at negedge
    task automatic cycle(input logic rdy, input logic redir, input logic [25:0] ra);
        logic        ack, req0, val0, disc;
        logic [31:0] d;
        logic [25:0] addr0;
        ack = 1'b0; d = 32'hDEAD_BEEF;
        if (IMEM_REQ) begin
            if (!mpend) begin
                mpend = 1;
                mwl = rand_waits ? int'($urandom_range(0, 3)) : waits;
            end
            if (mwl == 0) begin ack = 1'b1; d = mem_word(IMEM_ADDR); end
            else mwl--;
        end
        IMEM_ACK = ack; IMEM_DATA = d;
        INST_READY = rdy; REDIRECT = redir; REDIRECT_ADDR = ra;
        req0 = IMEM_REQ; addr0 = IMEM_ADDR; val0 = q.size() != 0;
        disc = redir || m_drop_pend;

        if (rdy && !val0 && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (val0 && rdy && !redir) void'(q.pop_front());
        if (req0 && ack) begin
            mpend = 0;
            if (disc) m_drops++;
            else begin
                chk("xfer_addr", 64'(addr0), 64'(m_pc));
                q.push_back({d, addr0});
                m_pc = m_pc + 26'd1;
                m_xfers++;
                m_last = addr0;
            end
            m_drop_pend = 0;
        end
        if (redir) begin
            q.delete();
            m_pc = ra;
            if (req0 && !ack) m_drop_pend = 1;
        end

        @(posedge CLK); #1;
        chk("q_count", 64'(Q_COUNT), 64'(q.size()));
        chk("inst_valid", 64'(INST_VALID), 64'(q.size() != 0));
        if (q.size() != 0) chk("head", {6'd0, INSTRUCTION, INST_PC}, 64'(q[0]));
        if (req0 && !ack) begin
            chk("req_hold",  64'(IMEM_REQ),  64'd1);
            chk("addr_hold", 64'(IMEM_ADDR), 64'(addr0));
        end
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", 64'(STALL_CNT), 64'(m_stall));
        chk("drop_cnt",  64'(DROP_CNT),  64'(m_drops));
`endif
        @(negedge CLK);
    endtask

    initial begin
        int n, xb;
        model_clear();
        waits = 0; rand_waits = 0;

        // Zero-wait streaming with decode always ready
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0);
        chk("stream_xfers", 64'(m_xfers), 64'd10);
        chk("stream_last",  64'(m_last),  64'h1009);

        // Fill with decode stalled, then one pop releases one fetch
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0);
        chk("fill_xfers", 64'(m_xfers),  64'd4);
        chk("fill_req",   64'(IMEM_REQ), 64'd0);
        chk("fill_count", 64'(Q_COUNT),  64'd4);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
        chk("refill_xfers", 64'(m_xfers), 64'd5);
        chk("refill_last",  64'(m_last),  64'h1004);
        chk("refill_req",   64'(IMEM_REQ), 64'd0);

        // Redirect while waiting on a slow memory
        do_reset();
        waits = 3;
        n = 0;
        while (!(IMEM_REQ && IMEM_ADDR == 26'h1002) && n < 50) begin cycle(1'b0, 1'b0, '0); n++; end
        chk("wait_reach", 64'(n < 50), 64'd1);
        cycle(1'b0, 1'b1, 26'h2000);
        chk("redir_count", 64'(Q_COUNT), 64'd0);
        n = 0;
        while (m_xfers < 3 && n < 40) begin cycle(1'b0, 1'b0, '0); n++; end
        chk("redir_last",  64'(m_last),  64'h2000);
        chk("redir_drops", 64'(m_drops), 64'd1);

        // Redirect coinciding with ACK and a pop
        do_reset();
        waits = 0;
        n = 0;
        while (!(IMEM_REQ && Q_COUNT != 0) && n < 50) begin cycle(1'b0, 1'b0, '0); n++; end
        chk("ackredir_reach", 64'(n < 50), 64'd1);
        xb = m_xfers;
        cycle(1'b1, 1'b1, 26'h3000);
        chk("ackredir_nopush", 64'(m_xfers), 64'(xb));
        chk("ackredir_valid",  64'(INST_VALID), 64'd0);
        n = 0;
        while (m_xfers < xb + 1 && n < 20) begin cycle(1'b0, 1'b0, '0); n++; end
        chk("ackredir_next", 64'(m_last), 64'h3000);

        // PC wraparound
        do_reset();
        cycle(1'b1, 1'b1, 26'h3FF_FFFF);
        n = 0;
        while (m_xfers < 2 && n < 20) begin cycle(1'b1, 1'b0, '0); n++; end
        chk("wrap_last", 64'(m_last), 64'd0);

        // Random traffic
        do_reset();
        rand_waits = 1;
        for (int i = 0; i < 800; i++) begin
            logic [25:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 26'h3FF_FFFE : 26'($urandom);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), ra);
        end
        chk("rand_progress", 64'(m_xfers > 50), 64'd1);
        rand_waits = 0;

`ifdef FETCH_STALL_CNT_EN
        do_reset();
        waits = 20;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);
        chk("stall5", 64'(STALL_CNT), 64'd5);
        cycle(1'b1, 1'b1, 26'h500);
        n = 0;
        while (m_drops == 0 && n < 40) begin cycle(1'b0, 1'b0, '0); n++; end
        chk("drop1", 64'(DROP_CNT), 64'd1);
        waits = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
